// File: rtl/en_value_rr_arbiter.sv
// Round-robin arbiter sharing one en/value channel
// among N_REQ requesters, with a sticky hold limit.
module en_value_rr_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [N_REQ-1:0]           i_req,
  input  logic [N_REQ*WIDTH-1:0]     i_value,
  output logic [N_REQ-1:0]           o_grant,
  output logic [$clog2(N_REQ)-1:0]   o_owner,
  output logic                       o_en,
  output logic [WIDTH-1:0]           o_value,
  output logic                       o_busy
);

  localparam int OW = $clog2(N_REQ);
  localparam int HW =
    (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t           state_q, state_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [WIDTH-1:0] value_d;
  logic [N_REQ-1:0] grant_d;
  logic [N_REQ-1:0] others;
  logic [OW-1:0]    nxt;
  logic             rel;
  logic             pre;

  function automatic logic [OW-1:0] sel(
    input logic [OW-1:0]    p,
    input logic [N_REQ-1:0] r
  );
    logic [OW-1:0] s;
    logic          found;
    int            idx;
    s     = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(p) + i) % N_REQ;
      if (!found && r[idx]) begin
        s     = OW'(idx);
        found = 1'b1;
      end
    end
    return s;
  endfunction

  // Release/preempt conditions for the current owner
  always_comb begin
    others = i_req & ~(N_REQ'(1) << owner_q);
    nxt    = (int'(owner_q) == N_REQ - 1)
           ? '0 : owner_q + OW'(1);
    rel    = !i_req[owner_q];
    pre    = !rel && (MAX_HOLD != 0)
           && (hold_q == HMAX) && (|others);
  end

  // Next-state, owner, pointer and hold decisions
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (|i_req) begin
          state_d = GRANT;
          owner_d = sel(ptr_q, i_req);
          hold_d  = HW'(1);
        end
      end
      GRANT: begin
        unique case (1'b1)
          rel: begin
            ptr_d = nxt;
            if (|others) begin
              owner_d = sel(nxt, i_req);
              hold_d  = HW'(1);
            end else begin
              state_d = IDLE;
              owner_d = '0;
              hold_d  = '0;
            end
          end
          pre: begin
            ptr_d   = nxt;
            owner_d = sel(nxt, others);
            hold_d  = HW'(1);
          end
          default: begin
            if (MAX_HOLD != 0 && hold_q != HMAX)
              hold_d = hold_q + HW'(1);
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values derived from the next owner
  always_comb begin
    grant_d = '0;
    value_d = '0;
    if (state_d == GRANT) begin
      grant_d = N_REQ'(1) << owner_d;
      value_d = i_value[int'(owner_d)*WIDTH +: WIDTH];
    end
  end

  // State and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      o_grant <= '0;
      o_en    <= 1'b0;
      o_value <= '0;
      o_busy  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      o_grant <= grant_d;
      o_en    <= (state_d == GRANT);
      o_value <= value_d;
      o_busy  <= (state_d == GRANT);
    end
  end

  assign o_owner = owner_q;

endmodule

// File: tb/tb_en_value_rr_arbiter.sv
// Bench for en_value_rr_arbiter: three hold limits
// driven in parallel against a behavioural model.
module tb_en_value_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] val;

  logic [3:0]  g  [3];
  logic [1:0]  ow [3];
  logic        en [3];
  logic [7:0]  v  [3];
  logic        bz [3];

  int checks = 0;
  int errors = 0;

  int mh    [3] = '{0, 4, 2};
  int mbusy [3];
  int mown  [3];
  int mptr  [3];
  int mhold [3];
  int mval  [3];

  always #5 clk = ~clk;

  for (genvar d = 0; d < 3; d++) begin : g_dut
    en_value_rr_arbiter #(
      .N_REQ(4),
      .WIDTH(8),
      .MAX_HOLD((d == 0) ? 0 : (d == 1) ? 4 : 2)
    ) u_dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_req(req),
      .i_value(val),
      .o_grant(g[d]),
      .o_owner(ow[d]),
      .o_en(en[d]),
      .o_value(v[d]),
      .o_busy(bz[d])
    );
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic int msel(int p, int r);
    for (int i = 0; i < 4; i++) begin
      int k;
      k = (p + i) % 4;
      if ((r >> k) & 1) return k;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      mbusy[d] = 0; mown[d] = 0; mptr[d] = 0;
      mhold[d] = 0; mval[d] = 0;
    end
  endtask

  task automatic model_edge();
    int r, o, oth;
    r = int'(req);
    for (int d = 0; d < 3; d++) begin
      if (mbusy[d] == 0) begin
        if (r != 0) begin
          mbusy[d] = 1;
          mown[d]  = msel(mptr[d], r);
          mhold[d] = 1;
        end
      end else begin
        o   = mown[d];
        oth = r & ~(1 << o);
        if (((r >> o) & 1) == 0) begin
          mptr[d] = (o + 1) % 4;
          if (oth != 0) begin
            mown[d]  = msel(mptr[d], r);
            mhold[d] = 1;
          end else begin
            mbusy[d] = 0; mown[d] = 0; mhold[d] = 0;
          end
        end else if (mh[d] != 0 && mhold[d] == mh[d]
                     && oth != 0) begin
          mptr[d]  = (o + 1) % 4;
          mown[d]  = msel(mptr[d], oth);
          mhold[d] = 1;
        end else if (mh[d] != 0 && mhold[d] < mh[d]) begin
          mhold[d] = mhold[d] + 1;
        end
      end
      mval[d] = mbusy[d] != 0
              ? int'((val >> (8 * mown[d])) & 32'hff) : 0;
    end
  endtask

  task automatic cmp_all();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d grant", d), 32'(g[d]),
          mbusy[d] != 0 ? 32'(1 << mown[d]) : 32'd0);
      chk($sformatf("d%0d owner", d), 32'(ow[d]),
          32'(mown[d]));
      chk($sformatf("d%0d en", d), 32'(en[d]),
          32'(mbusy[d]));
      chk($sformatf("d%0d busy", d), 32'(bz[d]),
          32'(mbusy[d]));
      chk($sformatf("d%0d value", d), 32'(v[d]),
          32'(mval[d]));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    cmp_all();
  endtask

  task automatic reset_mid();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    cmp_all();
    @(posedge clk);
    #1;
    cmp_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    val   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    req = 4'b0010;
    cyc();
    cyc();
    chk("pre-reset en", 32'(en[1]), 32'd1);
    reset_mid();
    chk("reset en", 32'(en[1]), 32'd0);
    req = '0;
    repeat (5) begin
      cyc();
      chk("idle busy", 32'(bz[1]), 32'd0);
    end

    req = 4'b0100;
    val = 32'h00A5_0000;
    cyc();
    chk("single grant", 32'(g[1]), 32'h4);
    chk("single owner", 32'(ow[1]), 32'd2);
    chk("single en", 32'(en[1]), 32'd1);
    chk("single value", 32'(v[1]), 32'hA5);
    val = 32'h003C_0000;
    cyc();
    chk("single resample", 32'(v[1]), 32'h3C);
    req = '0;
    cyc();
    chk("single drop en", 32'(en[1]), 32'd0);

    val = 32'h4433_2211;
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 4; i++) begin
        req = 4'(1 << i);
        cyc();
        chk("rotate owner", 32'(ow[0]), 32'(i));
        chk("rotate en", 32'(en[0]), 32'd1);
      end
    end
    req = '0;
    cyc();

    reset_mid();
    req = 4'b0011;
    for (int i = 0; i < 9; i++) begin
      int e;
      e = (i < 4) ? 0 : (i < 8) ? 1 : 0;
      cyc();
      chk("hold owner", 32'(ow[1]), 32'(e));
      chk("hold en", 32'(en[1]), 32'd1);
      chk("hold value", 32'(v[1]),
          e == 0 ? 32'h11 : 32'h22);
    end

    reset_mid();
    req = 4'b1000;
    val = 32'h7700_0099;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("solo owner", 32'(ow[2]), 32'd3);
    end
    req = 4'b1001;
    cyc();
    chk("wrap owner", 32'(ow[2]), 32'd0);
    chk("wrap value", 32'(v[2]), 32'h99);

    reset_mid();
    req = 4'b0010;
    val = 32'h4433_2211;
    cyc();
    chk("midgrant owner", 32'(ow[1]), 32'd1);
    req = 4'b1010;
    reset_mid();
    chk("midgrant clear", 32'(en[1]), 32'd0);
    cyc();
    chk("post reset owner", 32'(ow[1]), 32'd1);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 3)
        req = 4'($urandom_range(0, 15));
      val = $urandom;
      if ($urandom_range(0, 99) == 0) reset_mid();
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
